// File: rtl/div_pkg.sv
// Shared types and helpers for the multicycle divider (div_mc, div_lzc).
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DIVIDE,
        FIXUP,
        DONE
    } div_state_t;

    function automatic logic op_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_lzc.sv
// Combinational leading-zero counter; an all-zero input yields W.
module div_lzc #(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = CNT_W'(W);
        // Scan upward so the highest set bit is the last one to write.
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CNT_W'(W - 1 - i);
        end
    end

endmodule

// File: rtl/div_mc.sv
// Multicycle radix-2 restoring divider (RISC-V DIV/DIVU/REM/REMU) with valid/ready on both sides.
// Define DIV_EARLY_OUT_EN to skip the dividend's leading zeros using div_lzc.
module div_mc
    import div_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         div_ctrl,
    input  logic [D_WIDTH-1:0] numerator,
    input  logic [D_WIDTH-1:0] denominator,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] result,
    output logic [TAG_W-1:0]   tag_out,
    output logic               busy
);

    localparam int                 CNT_W   = $clog2(D_WIDTH) + 1;
    localparam logic [D_WIDTH-1:0] MIN_INT = {1'b1, {(D_WIDTH-1){1'b0}}};

    div_state_t         state;
    div_op_t            op;
    logic [CNT_W-1:0]   cnt;
    logic [D_WIDTH-1:0] dvd;      // dividend going in, quotient coming out
    logic [D_WIDTH:0]   rem;
    logic [D_WIDTH:0]   den;
    logic [TAG_W-1:0]   tag_q;
    logic               sign_q;
    logic               sign_r;

    logic               accept;
    logic               is_signed;
    logic               den_zero;
    logic               overflow;
    logic               dvd_zero;
    logic               quick;
    logic [D_WIDTH-1:0] abs_n;
    logic [D_WIDTH-1:0] abs_d;
    logic [D_WIDTH:0]   rem_next;
    logic [CNT_W-1:0]   lz;
    logic [D_WIDTH-1:0] quick_res;
    logic [D_WIDTH-1:0] fix_res;

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    assign is_signed = op_signed(op);
    assign abs_n     = (is_signed && dvd[D_WIDTH-1]) ? -dvd : dvd;
    assign abs_d     = (is_signed && den[D_WIDTH-1]) ? -den[D_WIDTH-1:0] : den[D_WIDTH-1:0];
    assign den_zero  = (den[D_WIDTH-1:0] == '0);
    assign overflow  = is_signed && (dvd == MIN_INT) && (den[D_WIDTH-1:0] == '1);
    assign rem_next  = {rem[D_WIDTH-1:0], dvd[D_WIDTH-1]};

`ifdef DIV_EARLY_OUT_EN
    div_lzc #(
        .W     (D_WIDTH),
        .CNT_W (CNT_W)
    ) u_lzc (
        .value (abs_n),
        .count (lz)
    );
    assign dvd_zero = (abs_n == '0);
`else
    assign lz       = '0;
    assign dvd_zero = 1'b0;
`endif

    assign quick = den_zero || overflow || dvd_zero;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        quick_res = '0;
        if (den_zero)      quick_res = op_rem(op) ? dvd : '1;
        else if (overflow) quick_res = op_rem(op) ? '0 : dvd;
    end

    always_comb begin
        fix_res = dvd;
        case (op)
            DIV:  fix_res = sign_q ? -dvd : dvd;
            DIVU: fix_res = dvd;
            REM:  fix_res = sign_r ? -rem[D_WIDTH-1:0] : rem[D_WIDTH-1:0];
            REMU: fix_res = rem[D_WIDTH-1:0];
            default: fix_res = dvd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (accept) state <= INIT;
                INIT: begin
                    if (quick) begin
                        result    <= quick_res;
                        tag_out   <= tag_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt   <= lz;
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(D_WIDTH - 1)) state <= FIXUP;
                end
                FIXUP: begin
                    result    <= fix_res;
                    tag_out   <= tag_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; each is loaded at accept or in INIT
    // before the FSM ever reads it, so only control state and visible outputs are reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op    <= div_op_t'(div_ctrl);
            dvd   <= numerator;
            den   <= {1'b0, denominator};
            tag_q <= tag_in;
        end else if (state == INIT) begin
            dvd    <= abs_n << lz;
            rem    <= '0;
            den    <= {1'b0, abs_d};
            sign_q <= dvd[D_WIDTH-1] ^ den[D_WIDTH-1];
            sign_r <= dvd[D_WIDTH-1];
        end else if (state == DIVIDE) begin
            if (rem_next >= den) begin
                rem <= rem_next - den;
                dvd <= {dvd[D_WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_next;
                dvd <= {dvd[D_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_div_mc.sv
// Bench for div_mc: directed RISC-V corner cases plus randomized traffic on a 32-bit and an
// 8-bit instance, scored against an arithmetic reference model through per-instance queues.
`timescale 1ns/1ps
module tb_div_mc;
    import div_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] res;
        bit          quick;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]  div_ctrl;
    logic [31:0] numerator, denominator, result;
    logic [4:0]  tag_in, tag_out;

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_busy;
    logic [1:0]  e_div_ctrl;
    logic [7:0]  e_numerator, e_denominator, e_result;
    logic [4:0]  e_tag_in, e_tag_out;

    exp_t q32[$];
    exp_t q8[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   bp_en    = 1'b0;

    div_mc #(.D_WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .div_ctrl(div_ctrl),
        .numerator(numerator), .denominator(denominator), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .tag_out(tag_out),
        .busy(busy)
    );

    div_mc #(.D_WIDTH(8), .TAG_W(5)) dut8 (
        .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .div_ctrl(e_div_ctrl),
        .numerator(e_numerator), .denominator(e_denominator), .tag_in(e_tag_in),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .result(e_result), .tag_out(e_tag_out),
        .busy(e_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V M-extension semantics on w-bit operands, using plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] n,
                                               input logic [31:0] d, input int w);
        longint half = longint'(1) << (w - 1);
        longint mask = 2 * half - 1;
        longint un   = longint'(n);
        longint ud   = longint'(d);
        longint sn   = (un >= half) ? un - 2 * half : un;
        longint sd   = (ud >= half) ? ud - 2 * half : ud;
        longint r;
        if (ud == 0) r = op[1] ? un : mask;
        else begin
            case (op)
                2'b00:   r = (sn == -half && sd == -1) ? un : sn / sd;
                2'b01:   r = un / ud;
                2'b10:   r = (sn == -half && sd == -1) ? 0 : sn % sd;
                default: r = un % ud;
            endcase
        end
        return 32'(r & mask);
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] n,
                                   input logic [31:0] d, input int w);
        longint half = longint'(1) << (w - 1);
        longint un   = longint'(n);
        longint sn   = (un >= half) ? un - 2 * half : un;
        longint sd   = (longint'(d) >= half) ? longint'(d) - 2 * half : longint'(d);
`ifdef DIV_EARLY_OUT_EN
        longint mag  = (!op[0] && sn < 0) ? -sn : un;
        int     bits = 0;
`endif
        if (d == 0) return 1;
        if (!op[0] && sn == -half && sd == -1) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mag == 0) return 1;
        while ((mag >> bits) != 0) bits++;
        return bits + 2;
`else
        return w + 2;
`endif
    endfunction

    function automatic logic [31:0] rand_opnd(input int w);
        logic [31:0] v;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1 << (w - 1);
            3: v = $urandom_range(0, 15);
            4: v = 32'd1;
            default: v = $urandom;
        endcase
        return v & mask;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] n, input logic [31:0] d,
                         input logic [4:0] tag, input logic [31:0] res, input int lat,
                         output int waited);
        exp_t e;
        in_valid = 1'b1; div_ctrl = op; numerator = n; denominator = d; tag_in = tag;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL w32_accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        end else begin
            e.res = res; e.tag = tag; e.acc = cyc + 1; e.lat = lat;
            q32.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; div_ctrl = 2'($urandom); numerator = $urandom;
        denominator = $urandom; tag_in = 5'($urandom);
    endtask

    task automatic issue8(input logic [1:0] op, input logic [7:0] n, input logic [7:0] d,
                          input logic [4:0] tag);
        exp_t e;
        int   waited = 0;
        e_in_valid = 1'b1; e_div_ctrl = op; e_numerator = n; e_denominator = d; e_tag_in = tag;
        @(negedge clk);
        while (!e_in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!e_in_ready) begin
            checks++; failures++;
            $display("FAIL w8_accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        end else begin
            e.res = ref_result(op, 32'(n), 32'(d), 8); e.tag = tag; e.acc = cyc + 1;
            e.lat = exp_lat(op, 32'(n), 32'(d), 8);
            q8.push_back(e);
        end
        @(posedge clk); #1;
        e_in_valid = 1'b0; e_div_ctrl = 2'($urandom); e_numerator = 8'($urandom);
        e_denominator = 8'($urandom); e_tag_in = 5'($urandom);
    endtask

    initial begin : mon32
        exp_t cur;
        bit   seen = 1'b0;
        bit   have = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    have = (q32.size() != 0);
                    if (!have) begin
                        checks++; failures++;
                        $display("FAIL w32_spurious_output: result 0x%0h with nothing outstanding", result);
                    end else begin
                        cur = q32.pop_front();
                        check("w32_result", result, cur.res);
                        check("w32_tag", 32'(tag_out), 32'(cur.tag));
                        check("w32_latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                    seen = 1'b1;
                end else if (have) begin
                    check("w32_hold_result", result, cur.res);
                    check("w32_hold_tag", 32'(tag_out), 32'(cur.tag));
                end
                if (out_ready) seen = 1'b0;
            end
        end
    end

    initial begin : mon8
        exp_t cur;
        bit   seen = 1'b0;
        bit   have = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (e_out_valid) begin
                if (!seen) begin
                    have = (q8.size() != 0);
                    if (!have) begin
                        checks++; failures++;
                        $display("FAIL w8_spurious_output: result 0x%0h with nothing outstanding", e_result);
                    end else begin
                        cur = q8.pop_front();
                        check("w8_result", 32'(e_result), cur.res);
                        check("w8_tag", 32'(e_tag_out), 32'(cur.tag));
                        check("w8_latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                    seen = 1'b1;
                end else if (have) begin
                    check("w8_hold_result", 32'(e_result), cur.res);
                end
                if (e_out_ready) seen = 1'b0;
            end
        end
    end

    initial begin : backpressure
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                out_ready   = ($urandom_range(0, 3) != 0);
                e_out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0 || busy || e_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d/%0d results still outstanding", q32.size(), q8.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic rand32(input int nops);
        logic [1:0]  op;
        logic [31:0] n, d;
        int          w;
        for (int i = 0; i < nops; i++) begin
            op = 2'($urandom_range(0, 3)); n = rand_opnd(32); d = rand_opnd(32);
            issue(op, n, d, 5'($urandom), ref_result(op, n, d, 32), exp_lat(op, n, d, 32), w);
        end
    endtask

    task automatic rand8(input int nops);
        for (int i = 0; i < nops; i++) begin
            issue8(2'($urandom_range(0, 3)), 8'(rand_opnd(8)), 8'(rand_opnd(8)), 5'($urandom));
        end
    endtask

    initial begin : main
        dir_t dirs[$];
        int   waited;
        in_valid = 1'b0; div_ctrl = 2'b00; numerator = '0; denominator = '0; tag_in = '0;
        out_ready = 1'b1;
        e_in_valid = 1'b0; e_div_ctrl = 2'b00; e_numerator = '0; e_denominator = '0;
        e_tag_in = '0; e_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_tag_out", 32'(tag_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        dirs.push_back(dir_t'{DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0});
        dirs.push_back(dir_t'{REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0});
        dirs.push_back(dir_t'{DIVU, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0});
        dirs.push_back(dir_t'{REMU, 32'hFFFF_FFF9, 32'd2,         32'd1,         1'b0});
        dirs.push_back(dir_t'{DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1});
        dirs.push_back(dir_t'{REMU, 32'd5,         32'd0,         32'd5,         1'b1});
        dirs.push_back(dir_t'{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        dirs.push_back(dir_t'{REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1});
        dirs.push_back(dir_t'{DIVU, 32'd1,         32'd1,         32'd1,         1'b0});
        dirs.push_back(dir_t'{DIVU, 32'd0,         32'd9,         32'd0,         1'b0});
        dirs.push_back(dir_t'{REM,  32'd0,         32'd0,         32'd0,         1'b1});
        dirs.push_back(dir_t'{DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
        dirs.push_back(dir_t'{REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0});
        foreach (dirs[i]) begin
            issue(dirs[i].op, dirs[i].n, dirs[i].d, 5'(i), dirs[i].res,
                  dirs[i].quick ? 1 : exp_lat(dirs[i].op, dirs[i].n, dirs[i].d, 32), waited);
        end
        drain();

        // Consumer stalls: output must hold, no new accept, and input churn is ignored.
        out_ready = 1'b0;
        issue(DIV, 32'd1000, 32'hFFFF_FFFD, 5'h1A, 32'hFFFF_FEB3,
              exp_lat(DIV, 32'd1000, 32'hFFFF_FFFD, 32), waited);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("bp_out_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            numerator = $urandom; denominator = $urandom; div_ctrl = 2'($urandom);
            tag_in = 5'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", result, 32'hFFFF_FEB3);
            check("bp_tag_out", 32'(tag_out), 32'h1A);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(REMU, 32'd100, 32'd7, 5'h07, 32'd2, exp_lat(REMU, 32'd100, 32'd7, 32), waited);
        check("b2b_accept_wait", 32'(waited), 32'd1);
        drain();

        // Reset in the middle of DIVIDE discards the operation.
        issue(DIVU, 32'hFFFF_0000, 32'd3, 5'h11, 32'd0, 0, waited);
        repeat (11) @(posedge clk);
        #1;
        check("rst_mid_busy", 32'(busy), 32'd1);
        q32.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_clear", 32'(busy), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_tag_out", 32'(tag_out), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        issue(DIVU, 32'd100, 32'd7, 5'h05, 32'd14, exp_lat(DIVU, 32'd100, 32'd7, 32), waited);
        drain();

        bp_en = 1'b1;
        fork
            rand32(700);
            rand8(2500);
        join
        bp_en = 1'b0;
        out_ready = 1'b1;
        e_out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #900000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
